// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: default sizes,
// FSM state encoding and the one-hot to binary index helper.
package rr_arb_pkg;

   localparam int N_REQ_DEF    = 16;
   localparam int IDX_W_DEF    = 4;
   localparam int MAX_HOLD_DEF = 8;
   localparam int HOLD_W       = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Binary index of a one-hot vector; an all-zero vector maps to 0.
   function automatic logic [IDX_W_DEF-1:0] onehot_to_idx(input logic [N_REQ_DEF-1:0] oh);
      logic [IDX_W_DEF-1:0] r;
      r = {IDX_W_DEF{1'b0}};
      for (int i = 0; i < N_REQ_DEF; i++) begin
         r = r | (oh[i] ? IDX_W_DEF'(i) : {IDX_W_DEF{1'b0}});
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface rr_grant_arbiter_if
   import rr_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IDX_W = IDX_W_DEF
);
   logic             en;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   modport master (
      output en, req,
      input  gnt, gnt_idx, gnt_valid, timeout
   );

   modport slave (
      input  en, req,
      output gnt, gnt_idx, gnt_valid, timeout
   );
endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// Masked priority encoder: lowest set bit at or above ptr, otherwise the
// lowest set bit overall. Two LSB-first encoders, masked result preferred.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int IDX_W = IDX_W_DEF
)(
   input  logic [N_REQ-1:0] vec,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [N_REQ-1:0] masked_s;
   logic [N_REQ-1:0] low_masked_s;
   logic [N_REQ-1:0] low_plain_s;

   // Isolate the lowest set bit of the masked and unmasked vectors, then pick.
   always_comb begin
      masked_s     = vec & ({N_REQ{1'b1}} << ptr);
      low_masked_s = masked_s & (~masked_s + N_REQ'(1'b1));
      low_plain_s  = vec & (~vec + N_REQ'(1'b1));
      if (|masked_s) begin
         found = 1'b1;
         idx   = IDX_W'(onehot_to_idx(N_REQ_DEF'(low_masked_s)));
      end else if (|vec) begin
         found = 1'b1;
         idx   = IDX_W'(onehot_to_idx(N_REQ_DEF'(low_plain_s)));
      end else begin
         found = 1'b0;
         idx   = {IDX_W{1'b0}};
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, binary index, and a
// hold timeout that forces handover after MAX_HOLD consecutive cycles.
module rr_grant_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int IDX_W    = IDX_W_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
)(
   input logic               clk,
   input logic               rst_n,
   rr_grant_arbiter_if.slave bus
);

   arb_state_t        state_r, state_n_s;
   logic [N_REQ-1:0]  gnt_r, gnt_n_s;
   logic [IDX_W-1:0]  gnt_idx_r, gnt_idx_n_s;
   logic              gnt_valid_r, gnt_valid_n_s;
   logic              timeout_r, timeout_n_s;
   logic [IDX_W-1:0]  ptr_r, ptr_n_s;
   logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_n_s;

   logic [N_REQ-1:0]  cand_s;
   logic              cur_req_s;
   logic              pick_found_s;
   logic [IDX_W-1:0]  pick_idx_s;
   logic              load_s;
   logic              drop_s;

   // Candidate vector: the current holder is excluded from its own handover.
   always_comb begin
      cur_req_s = |(bus.req & gnt_r);
      if (state_r == GRANT) begin
         cand_s = bus.req & ~gnt_r;
      end else begin
         cand_s = bus.req;
      end
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .vec   (cand_s),
      .ptr   (ptr_r),
      .found (pick_found_s),
      .idx   (pick_idx_s)
   );

   // Next-state: grant from IDLE, hold/release/timeout in GRANT.
   always_comb begin
      state_n_s     = state_r;
      gnt_n_s       = gnt_r;
      gnt_idx_n_s   = gnt_idx_r;
      gnt_valid_n_s = gnt_valid_r;
      ptr_n_s       = ptr_r;
      hold_cnt_n_s  = hold_cnt_r;
      timeout_n_s   = 1'b0;
      load_s        = 1'b0;
      drop_s        = 1'b0;

      case (state_r)
         IDLE: begin
            if (bus.en && pick_found_s) begin
               load_s = 1'b1;
            end else begin
               drop_s = 1'b1;
            end
         end
         GRANT: begin
            if (!cur_req_s || (hold_cnt_r == HOLD_W'(MAX_HOLD))) begin
               timeout_n_s = cur_req_s;
               if (bus.en && pick_found_s) begin
                  load_s = 1'b1;
               end else begin
                  drop_s = 1'b1;
               end
            end else if (hold_cnt_r != HOLD_W'(MAX_HOLD)) begin
               hold_cnt_n_s = hold_cnt_r + HOLD_W'(1);
            end else begin
               hold_cnt_n_s = hold_cnt_r;
            end
         end
         default: begin
            drop_s = 1'b1;
         end
      endcase

      if (load_s) begin
         state_n_s     = GRANT;
         gnt_n_s       = N_REQ'(1'b1) << pick_idx_s;
         gnt_idx_n_s   = pick_idx_s;
         gnt_valid_n_s = 1'b1;
         ptr_n_s       = pick_idx_s + IDX_W'(1);
         hold_cnt_n_s  = HOLD_W'(1);
      end else if (drop_s) begin
         state_n_s     = IDLE;
         gnt_n_s       = {N_REQ{1'b0}};
         gnt_idx_n_s   = {IDX_W{1'b0}};
         gnt_valid_n_s = 1'b0;
         hold_cnt_n_s  = {HOLD_W{1'b0}};
      end else begin
         state_n_s     = state_r;
      end
   end

   // State and output registers, cleared asynchronously by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         gnt_r       <= {N_REQ{1'b0}};
         gnt_idx_r   <= {IDX_W{1'b0}};
         gnt_valid_r <= 1'b0;
         timeout_r   <= 1'b0;
         ptr_r       <= {IDX_W{1'b0}};
         hold_cnt_r  <= {HOLD_W{1'b0}};
      end else begin
         state_r     <= state_n_s;
         gnt_r       <= gnt_n_s;
         gnt_idx_r   <= gnt_idx_n_s;
         gnt_valid_r <= gnt_valid_n_s;
         timeout_r   <= timeout_n_s;
         ptr_r       <= ptr_n_s;
         hold_cnt_r  <= hold_cnt_n_s;
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.gnt_idx   = gnt_idx_r;
   assign bus.gnt_valid = gnt_valid_r;
   assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_rr_grant_arbiter;

   localparam int N    = 16;
   localparam int MAXH = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   // reference model state
   int   m_owner;
   int   m_hold;
   int   m_ptr;
   logic m_to;

   rr_grant_arbiter_if bus ();

   rr_grant_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Rotating search from ptr: first set bit at or after ptr, wrapping.
   function automatic int ref_pick(input logic [15:0] v, input int p);
      int i;
      for (int k = 0; k < N; k++) begin
         i = (p + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_hold  = 0;
      m_ptr   = 0;
      m_to    = 1'b0;
   endtask

   task automatic model_grant(input int w);
      m_owner = w;
      m_hold  = 1;
      m_ptr   = (w + 1) % N;
   endtask

   // Advance the model by one rising edge using the inputs the DUT sampled.
   task automatic model_edge();
      logic [15:0] r;
      logic [15:0] cand;
      logic        held;
      int          w;
      r = bus.req;
      if (!rst_n) begin
         model_reset();
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         w = ref_pick(r, m_ptr);
         if (bus.en && w >= 0) model_grant(w);
      end else begin
         held = r[m_owner];
         if (!held || m_hold == MAXH) begin
            m_to = held;
            cand = r;
            cand[m_owner] = 1'b0;
            w = ref_pick(cand, m_ptr);
            if (bus.en && w >= 0) begin
               model_grant(w);
            end else begin
               m_owner = -1;
               m_hold  = 0;
            end
         end else begin
            m_hold++;
            m_to = 1'b0;
         end
      end
   endtask

   task automatic compare_model();
      logic [15:0] eg;
      eg = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
      check("gnt", bus.gnt, eg);
      check("gnt_idx", bus.gnt_idx, (m_owner >= 0) ? m_owner : 0);
      check("gnt_valid", bus.gnt_valid, m_owner >= 0);
      check("timeout", bus.timeout, m_to);
      check("onehot0", $onehot0(bus.gnt), 1'b1);
      check("idx_bit", bus.gnt_valid ? bus.gnt[bus.gnt_idx] : 1'b1, 1'b1);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   // Assert reset between edges; outputs must clear without a clock.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_gnt", bus.gnt, 16'h0000);
      check("rst_valid", bus.gnt_valid, 1'b0);
      check("rst_idx", bus.gnt_idx, 4'd0);
      check("rst_to", bus.timeout, 1'b0);
      @(posedge clk);
      model_reset();
      #2 rst_n = 1'b1;
   endtask

   int rot_exp[4] = '{5, 10, 15, 0};

   initial begin
      n_checks = 0;
      n_errors = 0;
      model_reset();
      rst_n   = 1'b0;
      bus.en  = 1'b0;
      bus.req = 16'h0000;
      #1;
      check("init_gnt", bus.gnt, 16'h0000);
      check("init_valid", bus.gnt_valid, 1'b0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // enable gating
      bus.en = 1'b0; bus.req = 16'hFFFF;
      repeat (3) cycle();
      check("en0_gnt", bus.gnt, 16'h0000);
      bus.en = 1'b1;
      cycle();
      check("en1_gnt", bus.gnt, 16'h0001);
      bus.en = 1'b0;
      repeat (7) cycle();
      check("en0_hold", bus.gnt, 16'h0001);
      cycle();
      check("en0_end_gnt", bus.gnt, 16'h0000);
      check("en0_end_to", bus.timeout, 1'b1);
      repeat (3) cycle();
      check("en0_wait", bus.gnt, 16'h0000);
      bus.en = 1'b1;
      cycle();
      check("en_back_idx", bus.gnt_idx, 4'd1);

      // reset mid-grant
      bus.req = 16'h0008;
      repeat (3) cycle();
      check("pre_rst_gnt", bus.gnt, 16'h0008);
      do_reset();
      cycle();
      check("post_rst_gnt", bus.gnt, 16'h0008);
      check("post_rst_idx", bus.gnt_idx, 4'd3);

      // round-robin rotation with timeouts
      do_reset();
      bus.req = 16'h8421;
      cycle();
      check("rot_first", bus.gnt_idx, 4'd0);
      for (int k = 0; k < 4; k++) begin
         repeat (8) cycle();
         check("rot_to", bus.timeout, 1'b1);
         check("rot_idx", bus.gnt_idx, rot_exp[k]);
         check("rot_valid", bus.gnt_valid, 1'b1);
      end

      // early release handover
      do_reset();
      bus.req = 16'h0104;
      cycle();
      check("early_first", bus.gnt, 16'h0004);
      repeat (3) cycle();
      bus.req = 16'h0100;
      cycle();
      check("early_gnt", bus.gnt, 16'h0100);
      check("early_idx", bus.gnt_idx, 4'd8);
      check("early_to", bus.timeout, 1'b0);

      // sole requester timeout
      do_reset();
      bus.req = 16'h0040;
      for (int k = 0; k < 2; k++) begin
         cycle();
         check("sole_gnt", bus.gnt, 16'h0040);
         repeat (7) cycle();
         check("sole_hold", bus.gnt, 16'h0040);
         cycle();
         check("sole_gap_gnt", bus.gnt, 16'h0000);
         check("sole_gap_to", bus.timeout, 1'b1);
      end

      // wrap and empty
      do_reset();
      bus.req = 16'h4000;
      cycle();
      check("wrap_14", bus.gnt_idx, 4'd14);
      bus.req = 16'h0003;
      cycle();
      check("wrap_gnt", bus.gnt, 16'h0001);
      bus.req = 16'h0000;
      cycle();
      check("empty_gnt", bus.gnt, 16'h0000);
      check("empty_idx", bus.gnt_idx, 4'd0);
      check("empty_valid", bus.gnt_valid, 1'b0);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.req = 16'($urandom) & 16'($urandom);
         end
         bus.en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
